// File: rtl/prog_feeder_pkg.sv
// Shared opcode constants, FSM state encoding and opcode decode helper for the
// program feeder.
package prog_feeder_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_END = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_END   = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   // True for opcodes that are handed to the processor with a Run strobe.
   function automatic logic op_is_exec(input logic [2:0] op);
      return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/prog_feeder_if.sv
// Loader and processor-side signals of the program feeder; master is the feeder,
// slave is the host/processor side.
interface prog_feeder_if #(parameter int ADDR_W = 5);

   logic              LoadEn;
   logic [ADDR_W-1:0] LoadAddr;
   logic [15:0]       LoadData;
   logic              Start;
   logic              Halt;
   logic              Done;
   logic [15:0]       DIN;
   logic              Run;
   logic              Busy;
   logic              Finished;
   logic              Error;
   logic [ADDR_W-1:0] PC;
   logic [15:0]       InstrCount;

   modport master (
      input  LoadEn, LoadAddr, LoadData, Start, Halt, Done,
      output DIN, Run, Busy, Finished, Error, PC, InstrCount
   );

   modport slave (
      output LoadEn, LoadAddr, LoadData, Start, Halt, Done,
      input  DIN, Run, Busy, Finished, Error, PC, InstrCount
   );

endinterface

// File: rtl/prog_feeder_mem.sv
// Program store: 2**ADDR_W x 16 register array, synchronous write, one full-word
// asynchronous read port and one opcode-only asynchronous read port.
module prog_feeder_mem #(
   parameter int ADDR_W = 5
) (
   input  logic              Clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata,
   input  logic [ADDR_W-1:0] op_addr,
   output logic [2:0]        op_data
);

   logic [15:0] mem_r [2**ADDR_W];

   // Write port; contents are intentionally left unreset.
   always_ff @(posedge Clock) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata   = mem_r[raddr];
   assign op_data = mem_r[op_addr][8:6];

endmodule

// File: rtl/prog_feeder.sv
// Program feeder: issues stored instructions to the bus processor one at a time.
// Optional Done watchdog is enabled by defining FEEDER_TIMEOUT_EN.
module prog_feeder
   import prog_feeder_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int TMO_W  = 4
) (
   input logic           Clock,
   input logic           Resetn,
   prog_feeder_if.master bus
);

   state_e            state_r;
   logic [ADDR_W-1:0] pc_r;
   logic [15:0]       instr_count_r;
   logic              mvi_r;
   logic              run_r;
   logic              busy_r;
   logic              finished_r;
   logic              error_r;
   logic [15:0]       word_s;
   logic [2:0]        op_s;
   logic [2:0]        look_op_s;
   logic [ADDR_W-1:0] look_pc_s;
   logic [ADDR_W-1:0] pc_inc_s;
   logic              idle_like_s;
   logic              start_go_s;
   logic              we_s;
   logic [15:0]       din_s;

`ifdef FEEDER_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
   logic [TMO_W-1:0] tmo_r;
`else
   localparam int TMO_W_UNUSED = TMO_W;
`endif

   assign pc_inc_s    = pc_r + ADDR_W'(1);
   assign op_s        = word_s[8:6];
   assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_END) || (state_r == ST_ERR);
   assign start_go_s  = idle_like_s && bus.Start && !bus.Halt;
   // A write racing an accepted Start is dropped so ISSUE sees the word Run was decided on.
   assign we_s        = bus.LoadEn && idle_like_s && !start_go_s;

   prog_feeder_mem #(.ADDR_W(ADDR_W)) u_mem (
      .Clock   (Clock),
      .we      (we_s),
      .waddr   (bus.LoadAddr),
      .wdata   (bus.LoadData),
      .raddr   (pc_r),
      .rdata   (word_s),
      .op_addr (look_pc_s),
      .op_data (look_op_s)
   );

   // Address that will be in ISSUE next cycle, so Run can be a registered output.
   always_comb begin
      look_pc_s = pc_r;
      case (state_r)
         ST_WAIT: begin
            if (mvi_r) begin
               look_pc_s = pc_inc_s;
            end else begin
               look_pc_s = pc_r;
            end
         end
         ST_ISSUE: look_pc_s = pc_r;
         default:  look_pc_s = {ADDR_W{1'b0}};
      endcase
   end

   // DIN: instruction word in ISSUE, immediate word during an mvi WAIT, zero otherwise.
   always_comb begin
      din_s = 16'h0000;
      case (state_r)
         ST_ISSUE: begin
            if (op_is_exec(op_s)) begin
               din_s = word_s;
            end else begin
               din_s = 16'h0000;
            end
         end
         ST_WAIT: begin
            if (mvi_r) begin
               din_s = word_s;
            end else begin
               din_s = 16'h0000;
            end
         end
         default: din_s = 16'h0000;
      endcase
   end

   // Issue FSM with PC, instruction counter, sticky flags and optional watchdog.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r       <= ST_IDLE;
         pc_r          <= {ADDR_W{1'b0}};
         instr_count_r <= 16'h0000;
         mvi_r         <= 1'b0;
         run_r         <= 1'b0;
         busy_r        <= 1'b0;
         finished_r    <= 1'b0;
         error_r       <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
         tmo_r         <= {TMO_W{1'b0}};
`endif
      end else if (bus.Halt) begin
         state_r <= ST_IDLE;
         run_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_END, ST_ERR: begin
               if (bus.Start) begin
                  state_r       <= ST_ISSUE;
                  pc_r          <= {ADDR_W{1'b0}};
                  instr_count_r <= 16'h0000;
                  finished_r    <= 1'b0;
                  error_r       <= 1'b0;
                  busy_r        <= 1'b1;
                  run_r         <= op_is_exec(look_op_s);
               end else begin
                  run_r <= 1'b0;
               end
            end
            ST_ISSUE: begin
               run_r <= 1'b0;
               if (op_s == OP_END) begin
                  state_r    <= ST_END;
                  finished_r <= 1'b1;
                  busy_r     <= 1'b0;
               end else if (!op_is_exec(op_s)) begin
                  state_r <= ST_ERR;
                  error_r <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_WAIT;
                  mvi_r   <= (op_s == OP_MVI);
                  pc_r    <= pc_inc_s;
`ifdef FEEDER_TIMEOUT_EN
                  tmo_r   <= {TMO_W{1'b0}};
`endif
               end
            end
            ST_WAIT: begin
               run_r <= 1'b0;
               if (bus.Done) begin
                  state_r <= ST_ISSUE;
                  run_r   <= op_is_exec(look_op_s);
                  if (mvi_r) begin
                     pc_r <= pc_inc_s;
                  end else begin
                     pc_r <= pc_r;
                  end
                  if (instr_count_r != 16'hFFFF) begin
                     instr_count_r <= instr_count_r + 16'd1;
                  end else begin
                     instr_count_r <= instr_count_r;
                  end
`ifdef FEEDER_TIMEOUT_EN
               end else if (tmo_r == TMO_LAST) begin
                  state_r <= ST_ERR;
                  error_r <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  tmo_r <= tmo_r + TMO_W'(1);
               end
`else
               end else begin
                  state_r <= ST_WAIT;
               end
`endif
            end
            default: begin
               state_r <= ST_IDLE;
               run_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.DIN        = din_s;
   assign bus.Run        = run_r;
   assign bus.Busy       = busy_r;
   assign bus.Finished   = finished_r;
   assign bus.Error      = error_r;
   assign bus.PC         = pc_r;
   assign bus.InstrCount = instr_count_r;

endmodule

// File: tb/tb_prog_feeder.sv
// Bench for prog_feeder: random programs checked against an instruction-level model,
// plus directed halt, reset, address-wrap and Done-watchdog (FEEDER_TIMEOUT_EN) cases.
module tb_prog_feeder;
   import prog_feeder_pkg::*;

   logic Clock;
   logic Resetn;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [15:0] mem_m [32];
   logic [15:0] sm [4];

   prog_feeder_if #(.ADDR_W(5)) bus ();
   prog_feeder_if #(.ADDR_W(2)) sbus ();

   prog_feeder #(.ADDR_W(5), .TMO_W(4)) u_dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));
   prog_feeder #(.ADDR_W(2), .TMO_W(4)) u_small (.Clock(Clock), .Resetn(Resetn), .bus(sbus));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 32; i++) mem_m[i] = 16'($urandom);
   endtask

   // Random legal instructions, then end or an illegal opcode; never reaches address 31.
   task automatic gen_prog();
      int a;
      int n;
      logic [2:0] op;
      a = 0;
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) begin
         op = 3'($urandom_range(0, 3));
         mem_m[a] = {7'($urandom), op, 6'($urandom)};
         a++;
         if (op == OP_MVI) begin
            mem_m[a] = 16'($urandom);
            a++;
         end
      end
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 6)) : OP_END;
      mem_m[a] = {7'($urandom), op, 6'($urandom)};
   endtask

   task automatic load_all();
      for (int i = 0; i < 32; i++) begin
         bus.LoadEn   = 1'b1;
         bus.LoadAddr = 5'(i);
         bus.LoadData = mem_m[i];
         @(negedge Clock);
      end
      bus.LoadEn = 1'b0;
   endtask

   // Start the program and act as the processor; fast uses the minimum Done latency.
   task automatic exec_prog(input bit fast);
      int pc;
      int cnt;
      int d;
      logic [15:0] w;
      logic [2:0] op;
      bit stopped;
      pc = 0;
      cnt = 0;
      stopped = 1'b0;
      bus.Start = 1'b1;
      @(negedge Clock);
      for (int g = 0; g < 40 && !stopped; g++) begin
         w = mem_m[pc];
         op = w[8:6];
         bus.Start  = 1'b0;
         bus.LoadEn = 1'b0;
         bus.Done   = 1'($urandom_range(0, 1));
         check_val("pc_issue", 32'(bus.PC), 32'(pc));
         check_val("cnt_issue", 32'(bus.InstrCount), 32'(cnt));
         check_val("fin_clear", 32'(bus.Finished), 32'd0);
         check_val("err_clear", 32'(bus.Error), 32'd0);
         if (op inside {OP_MV, OP_MVI, OP_ADD, OP_SUB}) begin
            check_val("run_issue", 32'(bus.Run), 32'd1);
            check_val("din_issue", 32'(bus.DIN), 32'(w));
            check_val("busy_issue", 32'(bus.Busy), 32'd1);
            if (op == OP_MV || op == OP_MVI) d = fast ? 0 : int'($urandom_range(0, 2));
            else d = fast ? 2 : int'($urandom_range(2, 4));
            for (int k = 0; k <= d; k++) begin
               @(negedge Clock);
               bus.Done     = (k == d);
               bus.Start    = ($urandom_range(0, 3) == 0);
               bus.LoadEn   = (k == 0) && ($urandom_range(0, 1) == 1);
               bus.LoadAddr = 5'($urandom_range(0, 31));
               bus.LoadData = 16'($urandom);
               check_val("run_wait", 32'(bus.Run), 32'd0);
               check_val("din_wait", 32'(bus.DIN),
                         (op == OP_MVI) ? 32'(mem_m[(pc + 1) % 32]) : 32'd0);
               check_val("pc_wait", 32'(bus.PC), 32'((pc + 1) % 32));
               check_val("busy_wait", 32'(bus.Busy), 32'd1);
            end
            @(negedge Clock);
            pc = (pc + ((op == OP_MVI) ? 2 : 1)) % 32;
            cnt++;
         end else begin
            check_val("run_noissue", 32'(bus.Run), 32'd0);
            @(negedge Clock);
            bus.Done = 1'b0;
            check_val("fin_stop", 32'(bus.Finished), 32'(op == OP_END));
            check_val("err_stop", 32'(bus.Error), 32'(op != OP_END));
            check_val("busy_stop", 32'(bus.Busy), 32'd0);
            check_val("run_stop", 32'(bus.Run), 32'd0);
            check_val("pc_stop", 32'(bus.PC), 32'(pc));
            check_val("cnt_stop", 32'(bus.InstrCount), 32'(cnt));
            stopped = 1'b1;
         end
      end
      check_val("prog_term", 32'(stopped), 32'd1);
   endtask

   initial begin
      bus.LoadEn = 1'b0; bus.LoadAddr = 5'd0; bus.LoadData = 16'h0000;
      bus.Start = 1'b0; bus.Halt = 1'b0; bus.Done = 1'b0;
      sbus.LoadEn = 1'b0; sbus.LoadAddr = 2'd0; sbus.LoadData = 16'h0000;
      sbus.Start = 1'b0; sbus.Halt = 1'b0; sbus.Done = 1'b0;
      Resetn = 1'b0;
      repeat (3) @(negedge Clock);
      check_val("rst_run", 32'(bus.Run), 32'd0);
      check_val("rst_busy", 32'(bus.Busy), 32'd0);
      check_val("rst_fin", 32'(bus.Finished), 32'd0);
      check_val("rst_err", 32'(bus.Error), 32'd0);
      check_val("rst_pc", 32'(bus.PC), 32'd0);
      check_val("rst_cnt", 32'(bus.InstrCount), 32'd0);
      check_val("rst_din", 32'(bus.DIN), 32'd0);
      Resetn = 1'b1;
      @(negedge Clock);

      // mvi with immediate, then end
      fill_rand();
      mem_m[0] = 16'h0040; mem_m[1] = 16'h0005; mem_m[2] = 16'h01C0;
      load_all();
      exec_prog(1'b1);

      // mv, add, end at minimum latency: Run 2 then 4 cycles apart
      fill_rand();
      mem_m[0] = 16'h0008; mem_m[1] = 16'h0081; mem_m[2] = 16'h01C0;
      load_all();
      exec_prog(1'b1);

      // illegal opcode at address 0
      fill_rand();
      mem_m[0] = 16'h0100;
      load_all();
      exec_prog(1'b0);

      // Halt together with Done in the third add WAIT cycle; LoadEn while busy
      fill_rand();
      mem_m[0] = 16'h0008; mem_m[1] = 16'h0081; mem_m[2] = 16'h01C0;
      load_all();
      bus.Start = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      @(negedge Clock);
      bus.Done = 1'b1;
      @(negedge Clock);
      bus.Done = 1'b0;
      check_val("halt_run_add", 32'(bus.Run), 32'd1);
      @(negedge Clock);
      bus.LoadEn = 1'b1; bus.LoadAddr = 5'd2; bus.LoadData = 16'h0008;
      @(negedge Clock);
      bus.LoadEn = 1'b0;
      @(negedge Clock);
      bus.Halt = 1'b1; bus.Done = 1'b1;
      @(negedge Clock);
      bus.Halt = 1'b0; bus.Done = 1'b0;
      check_val("halt_busy", 32'(bus.Busy), 32'd0);
      check_val("halt_run", 32'(bus.Run), 32'd0);
      check_val("halt_cnt", 32'(bus.InstrCount), 32'd1);
      check_val("halt_pc", 32'(bus.PC), 32'd2);
      check_val("halt_din", 32'(bus.DIN), 32'd0);
      repeat (3) @(negedge Clock);
      check_val("halt_run_later", 32'(bus.Run), 32'd0);
      exec_prog(1'b1);

      repeat (12) begin
         fill_rand();
         gen_prog();
         load_all();
         exec_prog(1'b0);
      end

      // asynchronous reset in the middle of an add
      fill_rand();
      mem_m[0] = 16'h0081; mem_m[1] = 16'h01C0;
      load_all();
      bus.Start = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      @(negedge Clock);
      check_val("mid_busy", 32'(bus.Busy), 32'd1);
      Resetn = 1'b0;
      #1;
      check_val("mid_rst_run", 32'(bus.Run), 32'd0);
      check_val("mid_rst_busy", 32'(bus.Busy), 32'd0);
      check_val("mid_rst_pc", 32'(bus.PC), 32'd0);
      @(negedge Clock);
      Resetn = 1'b1;
      @(negedge Clock);

      // Done never arrives
      bus.Start = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      check_val("tmo_run", 32'(bus.Run), 32'd1);
`ifdef FEEDER_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         @(negedge Clock);
         check_val("tmo_err", 32'(bus.Error), (k == 16) ? 32'd1 : 32'd0);
         check_val("tmo_busy", 32'(bus.Busy), (k == 16) ? 32'd0 : 32'd1);
      end
`else
      repeat (100) @(negedge Clock);
      check_val("notmo_busy", 32'(bus.Busy), 32'd1);
      check_val("notmo_err", 32'(bus.Error), 32'd0);
      check_val("notmo_run", 32'(bus.Run), 32'd0);
`endif
      bus.Halt = 1'b1;
      @(negedge Clock);
      bus.Halt = 1'b0;
      check_val("tmo_halt_busy", 32'(bus.Busy), 32'd0);

      // ADDR_W=2: mvi at the last address takes its immediate from address 0
      sm[0] = 16'h0008; sm[1] = 16'h0010; sm[2] = 16'h0018; sm[3] = 16'h0041;
      for (int i = 0; i < 4; i++) begin
         sbus.LoadEn = 1'b1; sbus.LoadAddr = 2'(i); sbus.LoadData = sm[i];
         @(negedge Clock);
      end
      sbus.LoadEn = 1'b0;
      sbus.Start = 1'b1;
      @(negedge Clock);
      sbus.Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_val("wrap_run", 32'(sbus.Run), 32'd1);
         check_val("wrap_din", 32'(sbus.DIN), 32'(sm[i]));
         check_val("wrap_pc", 32'(sbus.PC), 32'(i));
         @(negedge Clock);
         sbus.Done = 1'b1;
         check_val("wrap_din_wait", 32'(sbus.DIN), (i == 3) ? 32'(sm[0]) : 32'd0);
         check_val("wrap_pc_wait", 32'(sbus.PC), 32'((i + 1) % 4));
         @(negedge Clock);
         sbus.Done = 1'b0;
      end
      check_val("wrap_pc_after", 32'(sbus.PC), 32'd1);
      check_val("wrap_run_after", 32'(sbus.Run), 32'd1);
      check_val("wrap_din_after", 32'(sbus.DIN), 32'(sm[1]));
      check_val("wrap_cnt", 32'(sbus.InstrCount), 32'd4);
      sbus.Halt = 1'b1;
      @(negedge Clock);
      sbus.Halt = 1'b0;
      check_val("wrap_halt_busy", 32'(sbus.Busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
